alu_add_pipe: RTL and testbench
===============================

# alu_add_pipe

Parametrised, pipelined successor to the single-cycle ALU adder. Performs add, subtract, add-with-carry and saturating signed add on `DATA_W`-bit operands. The carry chain is split into `STAGES` equal slices, one register stage per slice. Sits between the register-read stage and writeback, and accepts one operation per cycle under a valid/ready handshake with backpressure.

## Interface
- `DATA_W`, 24: operand/result width; must be divisible by `STAGES`.
- `STAGES`, 3: pipeline depth and slice count; slice width `SW = DATA_W/STAGES`; range 1..DATA_W.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted on an edge when `in_valid & in_ready`.
- `in_0` in DATA_W: operand A.
- `in_1` in DATA_W: operand B.
- `in_mode` in 2: 00 ADD, 01 SUB, 10 ADC, 11 SADD.
- `in_cin` in 1: carry-in, used only in ADC.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result on an edge when `out_valid & out_ready`.
- `out` out DATA_W: result.
- `out_carry` out 1: unsigned carry-out; for SUB it is 1 for no borrow.
- `out_overflow` out 1: signed overflow of the unsaturated sum.
- `out_zero` out 1: `out == 0`.
- `out_neg` out 1: `out[DATA_W-1]`.

## Operation
- Effective operands: `B' = ~in_1` for SUB, otherwise `in_1`. `c0` = 1 for SUB, `in_cin` for ADC, 0 for ADD and SADD.
- Raw sum `{carry, s} = in_0 + B' + c0`, computed at DATA_W+1 bits.
- Overflow: `in_0[MSB] == B'[MSB]` and `s[MSB] != in_0[MSB]`. Evaluate it strictly from sign bits; zero operands must not be misclassified.
- SADD, overflow set: `out` clamps to `0x7F..F` when `in_0` is non-negative, and to `0x80..0` when negative. `out_overflow` stays 1.
- All other modes: `out = s`, which wraps modulo 2^DATA_W.
- `out_zero` and `out_neg` are computed on the final (post-clamp) `out`.
- Slice k adds bits `[k*SW +: SW]` using the carry registered from slice k-1. Operand upper bits, mode, and the partial result delay-match alongside.
- Flags and the clamp are resolved in the last stage.
- Every stage carries a valid bit. Bubbles propagate; they do not collapse.
- Reset values: `in_ready` 0 while `reset` is high; `out_valid` 0; `out` 0; all flags 0; all internal valid and data registers 0.

## Timing
- `advance = ~out_valid | out_ready`. The whole pipeline shifts on every edge where `advance` is 1; otherwise every register holds.
- `in_ready = advance & ~reset`. The combinational path `out_ready -> in_ready` is permitted and documented for the upstream stage.
- Latency: an operation accepted at edge T presents `out_valid` after edge T+STAGES−1. With STAGES=1 the result appears right after the accepting edge.
- Throughput is 1 op/cycle while `out_ready` is held at 1.
- While `out_valid & ~out_ready`: `out` and all flags stay stable, and no input is accepted.
- Accept and drain on the same edge is legal and loses nothing.
- Reset asserted mid-operation: all in-flight operations are discarded and the outputs go to their reset values immediately (asynchronous). The first op accepted after release has the full latency.
- Carry-chain depth per cycle is SW bits. No path may span slices without a register.

## Structure
- Shared definitions header/package holds:
  - mode encodings `ALU_ADD_MODE_ADD/SUB/ADC/SADD`;
  - the existing `ENABLE`/`DISABLE` and `ALUDATA` width constants.
- Sub-module `alu_add_slice`: SW-bit adder with carry-in and carry-out, plus output register and stall enable. Instantiate it STAGES times in a generate loop.
- The top level contains the delay-match registers, valid chain, handshake, flag logic and clamp.

## Test plan
Defaults DATA_W=24, STAGES=3.
- ADD 0x7FFFFF + 0x000001 -> `out` 0x800000, overflow 1, carry 0, neg 1. `out_valid` appears 3 edges after accept.
- SUB 0x000005 − 0x000007 -> `out` 0xFFFFFE, carry 0, overflow 0. SUB 0x000005 − 0x000005 -> `out` 0, zero 1, carry 1.
- ADC 0xFFFFFF + 0x000000, cin 1 -> `out` 0, carry 1, zero 1, overflow 0. This checks the carry ripple through all 3 slices.
- SADD 0x800000 + 0xFFFFFF -> `out` 0x800000, overflow 1. SADD 0x600000 + 0x300000 -> `out` 0x7FFFFF, overflow 1. SADD 0x000003 + 0xFFFFFE -> `out` 0x000001, overflow 0.
- 8 back-to-back ops with `out_ready` toggling 1,0,1,0… -> all 8 results arrive in order, none dropped or duplicated, and outputs are stable during stall cycles.
- `reset` pulsed with 2 ops in flight -> `out_valid` drops without waiting for a clock edge and outputs read 0. After release, a new ADD 1+1 returns 0x000002 after 3 edges.

Source files
------------

// File: rtl/alu_add_pipe_pkg.sv
// Shared definitions for the pipelined ALU adder: mode encodings and
// legacy width/enable constants carried over from the single-cycle adder.
package alu_add_pipe_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam int   ALUDATA = 24;

    typedef enum logic [1:0] {
        ALU_ADD_MODE_ADD  = 2'b00,
        ALU_ADD_MODE_SUB  = 2'b01,
        ALU_ADD_MODE_ADC  = 2'b10,
        ALU_ADD_MODE_SADD = 2'b11
    } alu_add_mode_e;

endpackage

// File: rtl/alu_add_slice.sv
// One SW-bit slice of the carry chain: ripple add plus a stall-able
// output register for the slice sum and carry-out.
module alu_add_slice
    import alu_add_pipe_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

    // Slice result register, frozen while the pipeline is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en == ENABLE) begin
            sum  <= total[SW-1:0];
            cout <= total[SW];
        end
    end

endmodule

// File: rtl/alu_add_pipe.sv
// Pipelined add/sub/adc/saturating-add unit: the carry chain is cut into
// STAGES slices with one register stage each; flags and clamp at the tail.
module alu_add_pipe
    import alu_add_pipe_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [1:0]        in_mode,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_carry,
    output logic              out_overflow,
    output logic              out_zero,
    output logic              out_neg
);

    localparam int SW  = DATA_W / STAGES;
    localparam int MSB = DATA_W - 1;

    function automatic logic [DATA_W-1:0] sat_limit(input logic neg);
        sat_limit = neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    logic                           advance;
    logic [DATA_W-1:0]              b_eff;
    logic                           c0;
    logic [STAGES-1:0]              valid_r;
    logic [STAGES-1:0][DATA_W-1:0]  a_r;
    logic [STAGES-1:0][DATA_W-1:0]  b_r;
    logic [STAGES-1:0][DATA_W-1:0]  part_r;
    logic [STAGES-1:0][1:0]         mode_r;
    logic [STAGES-1:0][DATA_W-1:0]  full_s;
    logic [STAGES-1:0][SW-1:0]      sl_sum;
    logic [STAGES-1:0]              sl_cout;
    logic [DATA_W-1:0]              raw_s;
    logic [DATA_W-1:0]              res_s;
    logic                           ovf_s;
    logic                           unused_bits;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance & ~reset;

    // Effective B operand and carry-in per mode.
    always_comb begin
        b_eff = in_1;
        c0    = 1'b0;
        case (alu_add_mode_e'(in_mode))
            ALU_ADD_MODE_ADD:  begin b_eff = in_1;  c0 = 1'b0;   end
            ALU_ADD_MODE_SUB:  begin b_eff = ~in_1; c0 = 1'b1;   end
            ALU_ADD_MODE_ADC:  begin b_eff = in_1;  c0 = in_cin; end
            ALU_ADD_MODE_SADD: begin b_eff = in_1;  c0 = 1'b0;   end
            default:           begin b_eff = in_1;  c0 = 1'b0;   end
        endcase
    end

    // Slice k reads the operand bits delayed by k stages and the carry of slice k-1.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_first
            alu_add_slice #(.SW(SW)) u_slice (
                .clk  (clk),
                .reset(reset),
                .en   (advance),
                .a    (in_0[SW-1:0]),
                .b    (b_eff[SW-1:0]),
                .cin  (c0),
                .sum  (sl_sum[k]),
                .cout (sl_cout[k])
            );
        end else begin : g_rest
            alu_add_slice #(.SW(SW)) u_slice (
                .clk  (clk),
                .reset(reset),
                .en   (advance),
                .a    (a_r[k-1][k*SW +: SW]),
                .b    (b_r[k-1][k*SW +: SW]),
                .cin  (sl_cout[k-1]),
                .sum  (sl_sum[k]),
                .cout (sl_cout[k])
            );
        end
    end

    // Partial result at stage k: lower slices from earlier stages plus slice k.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            full_s[k]               = part_r[k];
            full_s[k][k*SW +: SW]   = sl_sum[k];
        end
    end

    // Valid chain and delay-matched operands, mode and partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
            a_r     <= '0;
            b_r     <= '0;
            part_r  <= '0;
            mode_r  <= '0;
        end else if (advance) begin
            valid_r[0] <= in_valid;
            a_r[0]     <= in_0;
            b_r[0]     <= b_eff;
            part_r[0]  <= '0;
            mode_r[0]  <= in_mode;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                a_r[k]     <= a_r[k-1];
                b_r[k]     <= b_r[k-1];
                part_r[k]  <= full_s[k-1];
                mode_r[k]  <= mode_r[k-1];
            end
        end
    end

    assign raw_s = full_s[STAGES-1];
    assign ovf_s = (a_r[STAGES-1][MSB] == b_r[STAGES-1][MSB]) &&
                   (raw_s[MSB] != a_r[STAGES-1][MSB]);

    // Saturation clamp, only for SADD on overflow.
    always_comb begin
        if ((mode_r[STAGES-1] == ALU_ADD_MODE_SADD) && ovf_s) begin
            res_s = sat_limit(a_r[STAGES-1][MSB]);
        end else begin
            res_s = raw_s;
        end
    end

    assign out_valid    = valid_r[STAGES-1];
    assign out          = res_s;
    assign out_carry    = sl_cout[STAGES-1];
    assign out_overflow = ovf_s;
    assign out_zero     = out_valid & (res_s == '0);
    assign out_neg      = res_s[MSB];

    // Operand bits below each stage's slice are carried but never read.
    assign unused_bits = ^{a_r, b_r, part_r, full_s};

endmodule

// File: tb/tb_alu_add_pipe.sv
// Directed self-checking bench for alu_add_pipe (DATA_W=24, STAGES=3).
module tb_alu_add_pipe;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_0;
    logic [DW-1:0] in_1;
    logic [1:0]    in_mode;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out;
    logic          out_carry;
    logic          out_overflow;
    logic          out_zero;
    logic          out_neg;

    int tests = 0;
    int fails = 0;

    alu_add_pipe #(.DATA_W(DW), .STAGES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_0        (in_0),
        .in_1        (in_1),
        .in_mode     (in_mode),
        .in_cin      (in_cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .out_carry   (out_carry),
        .out_overflow(out_overflow),
        .out_zero    (out_zero),
        .out_neg     (out_neg)
    );

    always #5 clk = ~clk;

    // Issue one op with out_ready held high; return edges counted until out_valid.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [1:0] m, input logic c, output int lat);
        @(negedge clk);
        in_0 = a; in_1 = b; in_mode = m; in_cin = c;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, out, out_carry, out_overflow, out_zero, out_neg} !== 30'h0) begin
            fails++;
            $display("FAIL reset_state: got %h, want 0",
                     {in_ready, out_valid, out, out_carry, out_overflow, out_zero, out_neg});
        end
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_vectors(input string name, input logic [1:0] m, input int n,
                                input logic [DW-1:0] va[4], input logic [DW-1:0] vb[4],
                                input logic vc[4], input logic [27:0] ve[4]);
        int lat;
        for (int i = 0; i < n; i++) begin
            run_op(va[i], vb[i], m, vc[i], lat);
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL %s_latency[%0d]: got %0d, want 3", name, i, lat);
            end
            tests++;
            if ({out, out_carry, out_overflow, out_zero, out_neg} !== ve[i]) begin
                fails++;
                $display("FAIL %s_result[%0d]: got %h, want %h (out,c/o/z/n)", name, i,
                         {out, out_carry, out_overflow, out_zero, out_neg}, ve[i]);
            end
        end
    endtask

    task automatic test_add;
        test_vectors("add", 2'b00, 3,
            '{24'h7FFFFF, 24'h000000, 24'h000001, 24'h0},
            '{24'h000001, 24'h000000, 24'h000001, 24'h0},
            '{1'b0, 1'b0, 1'b1, 1'b0},
            '{28'h8000005, 28'h0000002, 28'h0000020, 28'h0});
    endtask

    task automatic test_sub;
        test_vectors("sub", 2'b01, 2,
            '{24'h000005, 24'h000005, 24'h0, 24'h0},
            '{24'h000007, 24'h000005, 24'h0, 24'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{28'hFFFFFE1, 28'h000000A, 28'h0, 28'h0});
    endtask

    task automatic test_adc;
        test_vectors("adc", 2'b10, 2,
            '{24'hFFFFFF, 24'h7FFFFF, 24'h0, 24'h0},
            '{24'h000000, 24'h000000, 24'h0, 24'h0},
            '{1'b1, 1'b0, 1'b0, 1'b0},
            '{28'h000000A, 28'h7FFFFF0, 28'h0, 28'h0});
    endtask

    task automatic test_sadd;
        test_vectors("sadd", 2'b11, 3,
            '{24'h800000, 24'h600000, 24'h000003, 24'h0},
            '{24'hFFFFFF, 24'h300000, 24'hFFFFFE, 24'h0},
            '{1'b0, 1'b0, 1'b0, 1'b0},
            '{28'h800000D, 28'h7FFFFF4, 28'h0000018, 28'h0});
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_q [8];
        int            sent = 0;
        int            recv = 0;
        logic          stalled = 1'b0;
        logic [27:0]   held = '0;
        for (int i = 0; i < 8; i++) exp_q[i] = 24'h010008 + DW'(i);
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = ((cyc % 2) == 0);
            in_valid  = (sent < 8);
            in_0      = 24'h00FFF8 + DW'(sent);
            in_1      = 24'h000010;
            in_mode   = 2'b00;
            in_cin    = 1'b0;
            #1;
            if (stalled) begin
                tests++;
                if ({out, out_carry, out_overflow, out_zero, out_neg} !== held) begin
                    fails++;
                    $display("FAIL b2b_stall_hold: got %h, want %h",
                             {out, out_carry, out_overflow, out_zero, out_neg}, held);
                end
            end
            if (out_valid && !out_ready) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_stall_ready: got %b, want 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (out !== exp_q[recv]) begin
                    fails++;
                    $display("FAIL b2b_result[%0d]: got %h, want %h", recv, out, exp_q[recv]);
                end
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = {out, out_carry, out_overflow, out_zero, out_neg};
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (recv !== 8) begin
            fails++;
            $display("FAIL b2b_count: got %0d, want 8", recv);
        end
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_extra: got out_valid %b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight;
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_0 = 24'h600000; in_1 = 24'h300000; in_mode = 2'b11; in_cin = 1'b0;
        @(posedge clk);
        #1;
        in_0 = 24'h7FFFFF; in_1 = 24'h000001; in_mode = 2'b00;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midflight_pending: got out_valid %b, want 1", out_valid);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({in_ready, out_valid, out, out_carry, out_overflow, out_zero, out_neg} !== 30'h0) begin
            fails++;
            $display("FAIL midflight_async_clear: got %h, want 0",
                     {in_ready, out_valid, out, out_carry, out_overflow, out_zero, out_neg});
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(24'h000001, 24'h000001, 2'b00, 1'b0, lat);
        tests++;
        if (lat !== 3) begin
            fails++;
            $display("FAIL post_reset_latency: got %0d, want 3", lat);
        end
        tests++;
        if (out !== 24'h000002) begin
            fails++;
            $display("FAIL post_reset_result: got %h, want 000002", out);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_0      = '0;
        in_1      = '0;
        in_mode   = 2'b00;
        in_cin    = 1'b0;
        repeat (2) @(posedge clk);
        test_reset;
        test_add;
        test_sub;
        test_adc;
        test_sadd;
        test_back_to_back;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
